// File: rtl/neuron_mac_seq_if.sv
// rtl/neuron_mac_seq_if.sv - activation input and result output streams of the perceptron MAC
interface neuron_mac_seq_if #(
  parameter int ACC_W = 40
);
  logic             x_valid;
  logic             x_ready;
  logic [15:0]      x_data;
  logic             x_last;
  logic             y_valid;
  logic             y_ready;
  logic [ACC_W-1:0] y_sum;
  logic             y_fire;

  modport master (
    output x_valid, x_data, x_last, y_ready,
    input  x_ready, y_valid, y_sum, y_fire
  );

  modport slave (
    input  x_valid, x_data, x_last, y_ready,
    output x_ready, y_valid, y_sum, y_fire
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// rtl/neuron_mac_seq.sv - perceptron multiply-accumulate stage fed by a 1-cycle-latency weight ROM
module neuron_mac_seq #(
  parameter int                      N_INPUTS  = 10,
  parameter int                      BASE_ADDR = 1,
  parameter int                      ACC_W     = 40,
  parameter logic signed [ACC_W-1:0] BIAS      = '0,
  parameter logic signed [ACC_W-1:0] THRESHOLD = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_dout,
  output logic        err,
  neuron_mac_seq_if.slave s
);
  localparam int             IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    x_hs;
  logic                    is_last;

  assign x_hs     = s.x_valid & s.x_ready;
  assign is_last  = (idx == IDX_LAST);
  assign prod     = $signed(rom_dout) * $signed(s.x_data);
  assign prod_ext = ACC_W'(prod);

  // Look-ahead: the ROM latches the address on the handshake edge, so rom_dout
  // already holds w[idx] in the following cycle.
  always_comb begin
    idx_nxt = idx;
    if (!rst_n || state == ST_OUT || (x_hs && is_last)) begin
      idx_nxt = '0;
    end else if (x_hs) begin
      idx_nxt = idx + 1'b1;
    end
  end

  assign rom_addr = 16'(BASE_ADDR + int'(idx_nxt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC: if (x_hs && is_last) state_nxt = ST_OUT;
      ST_OUT: if (s.y_ready)       state_nxt = ST_ACC;
      default:                     state_nxt = ST_ACC;
    endcase
  end

  always_comb begin
    s.x_ready = (state == ST_ACC);
    s.y_valid = (state == ST_OUT);
    s.y_sum   = acc;
    s.y_fire  = (acc > THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      acc <= BIAS;
      err <= 1'b0;
    end else begin
      idx <= idx_nxt;
      if (x_hs) begin
        acc <= acc + prod_ext;
        if (s.x_last != is_last) err <= 1'b1;
      end else if (state == ST_OUT && s.y_ready) begin
        acc <= BIAS;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb/tb_neuron_mac_seq.sv - directed bench with a vector-level reference model for neuron_mac_seq
module tb_neuron_mac_seq;
  localparam int               N    = 10;
  localparam int               BASE = 1;
  localparam logic signed [39:0] TH = 40'sd20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic [15:0] rom_dout;
  logic        err;

  always #5 clk = ~clk;

  neuron_mac_seq_if #(.ACC_W(40)) bus ();

  neuron_mac_seq #(
    .N_INPUTS (N),
    .BASE_ADDR(BASE),
    .ACC_W    (40),
    .THRESHOLD(TH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rom_addr(rom_addr),
    .rom_dout(rom_dout),
    .err     (err),
    .s       (bus.slave)
  );

  logic [15:0] rom_mem [0:65535];
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted inputs per vector and sums weight*activation.
  int                  m_cnt = 0;
  logic signed [39:0]  m_acc = '0;
  logic signed [39:0]  m_sum = '0;
  logic                m_out = 1'b0;
  logic                m_err = 1'b0;
  logic                armed = 1'b0;

  always @(negedge clk) begin : model
    logic signed [15:0] wv;
    logic signed [15:0] xv;
    logic signed [31:0] pv;
    if (armed) begin
      check("y_valid", 40'(bus.y_valid), 40'(m_out));
      check("x_ready", 40'(bus.x_ready), 40'(!m_out));
      check("err", 40'(err), 40'(m_err));
      if (m_out) begin
        check("y_sum", bus.y_sum, m_sum);
        check("y_fire", 40'(bus.y_fire), 40'(m_sum > TH));
      end else begin
        check("rom_dout", 40'(rom_dout), 40'(rom_mem[16'(BASE + m_cnt)]));
      end
    end
    if (!rst_n) begin
      m_cnt = 0;
      m_acc = '0;
      m_out = 1'b0;
      m_err = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      if (!m_out && bus.x_valid) begin
        if (bus.x_last != (m_cnt == N - 1)) m_err = 1'b1;
        wv = rom_mem[16'(BASE + m_cnt)];
        xv = bus.x_data;
        pv = wv * xv;
        m_acc = m_acc + pv;
        m_cnt++;
        if (m_cnt == N) begin
          m_sum = m_acc;
          m_acc = '0;
          m_cnt = 0;
          m_out = 1'b1;
        end
      end else if (m_out && bus.y_ready) begin
        m_out = 1'b0;
      end
    end
    if (armed) check("rom_addr", 40'(rom_addr), 40'(16'(BASE + m_cnt)));
  end

  // mode 0: all ones, 1: ramp 1..n, 2: all -1
  task automatic send_vec(input int mode, input int gap, input int last_pos, input int n);
    for (int i = 0; i < n; i++) begin
      bus.x_valid = 1'b1;
      bus.x_data  = 16'((mode == 1) ? i + 1 : (mode == 2) ? -1 : 1);
      bus.x_last  = (i == last_pos);
      @(posedge clk);
      #1;
      bus.x_valid = 1'b0;
      bus.x_last  = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic get_result(input logic [39:0] es, input logic ef, input int hold);
    @(negedge clk);
    check("latency", 40'(bus.y_valid), 40'd1);
    check("lit_sum", bus.y_sum, es);
    check("lit_fire", 40'(bus.y_fire), 40'(ef));
    if (hold > 0) begin
      @(posedge clk);
      #1;
      bus.x_valid = 1'b1;
      bus.x_data  = 16'd7;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_sum", bus.y_sum, es);
        check("hold_fire", 40'(bus.y_fire), 40'(ef));
        check("hold_x_ready", 40'(bus.x_ready), 40'd0);
      end
      @(posedge clk);
      #1;
      bus.x_valid = 1'b0;
      bus.y_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom_mem[a] = 16'd0;
    rom_mem[1] = 16'd1;
    rom_mem[2] = 16'd3;
    rom_mem[3] = 16'd4;
    rom_mem[4] = 16'd5;
    rom_mem[5] = 16'd6;
    rom_mem[6] = 16'd8;

    rst_n       = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_data  = 16'd0;
    bus.x_last  = 1'b0;
    bus.y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_y_valid", 40'(bus.y_valid), 40'd0);
    check("rst_x_ready", 40'(bus.x_ready), 40'd1);
    check("rst_err", 40'(err), 40'd0);
    check("rst_rom_dout", 40'(rom_dout), 40'd1);
    @(posedge clk);
    #1;

    send_vec(0, 0, 9, 10);
    get_result(40'd27, 1'b1, 0);
    check("err_clean", 40'(err), 40'd0);

    send_vec(1, 0, 9, 10);
    get_result(40'd117, 1'b1, 0);

    send_vec(2, 0, 9, 10);
    get_result(40'hFF_FFFF_FFE5, 1'b0, 0);

    send_vec(1, 3, 9, 10);
    get_result(40'd117, 1'b1, 0);

    bus.y_ready = 1'b0;
    send_vec(0, 0, 9, 10);
    get_result(40'd27, 1'b1, 5);
    send_vec(0, 0, 9, 10);
    get_result(40'd27, 1'b1, 0);

    send_vec(0, 0, 5, 10);
    get_result(40'd27, 1'b1, 0);
    check("err_sticky", 40'(err), 40'd1);

    send_vec(0, 0, 9, 4);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("err_after_rst", 40'(err), 40'd0);
    @(posedge clk);
    #1;
    send_vec(0, 0, 9, 10);
    get_result(40'd27, 1'b1, 0);
    check("err_final", 40'(err), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
Perceptron accumulate stage that sits directly downstream of a neuron weight ROM (16-bit address in, 16-bit registered data out, 1-cycle read latency).
- Accepts one input activation per handshake and multiplies it by the matching ROM weight.
- Accumulates the N_INPUTS products on top of a bias.
- Presents the signed sum and a threshold "fire" bit on a valid/ready output.
- Drives the ROM address with look-ahead, so the block sustains one input per cycle without bubbles.

Parameters:
N_INPUTS, 10, number of weights/inputs per vector (1..256)
BASE_ADDR, 1, ROM address of weight for input index 0; input i reads BASE_ADDR+i
ACC_W, 40, accumulator width, signed
BIAS, 0, signed ACC_W initial accumulator value per vector
THRESHOLD, 0, signed ACC_W; fire when sum > THRESHOLD

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
rom_addr  out  16  address to weight ROM (combinational look-ahead)
rom_dout  in  16  weight from ROM, signed two's complement, valid 1 cycle after address
x_valid  in  1  input activation valid
x_ready  out  1  block accepts input
x_data  in  16  input activation, signed
x_last  in  1  sender marks final input of vector
y_valid  out  1  result valid
y_ready  in  1  consumer accepts result
y_sum  out  ACC_W  signed accumulated sum
y_fire  out  1  y_sum > THRESHOLD (signed)
err  out  1  sticky x_last/index mismatch flag

Behaviour:
- Reset (rst_n low at posedge): state=ACC, idx=0, acc=BIAS, err=0. Resulting outputs: y_valid=0, x_ready=1. Reset clears a partially accumulated vector with no output.
- During reset, rom_addr=BASE_ADDR. Since reset lasts at least one edge, rom_dout already holds w[0] at deassertion.
- Counter and look-ahead address:
  - idx is 0..N_INPUTS-1.
  - idx_nxt = 0 if (last handshake or state OUT or reset); else idx+1 if x handshake; else idx.
  - rom_addr = BASE_ADDR + idx_nxt, truncated to 16 bits.
  - The ROM therefore samples the next address on the same edge as the handshake, and rom_dout equals w[idx] in every cycle of ACC.
- Stall: if x_valid is low, idx and rom_addr hold, so rom_dout stays stable.
- State ACC:
  - x_ready=1, y_valid=0.
  - On x_valid&x_ready: acc <= acc + sext(rom_dout * x_data), a 32-bit signed product sign-extended to ACC_W.
  - Arithmetic wraps modulo 2^ACC_W. With the defaults, 40 bits cannot overflow for N_INPUTS ≤ 256.
  - On the handshake with idx==N_INPUTS-1: idx<=0 and state<=OUT. The final acc is registered on the same edge.
  - x_last check: if x_last != (idx==N_INPUTS-1) on any handshake, err<=1 (sticky until reset). The vector length is always N_INPUTS regardless of x_last.
- State OUT:
  - y_valid=1, x_ready=0. y_sum=acc, y_fire=(acc > THRESHOLD) signed.
  - Both outputs are stable while y_valid&!y_ready.
  - On y_ready: state<=ACC and acc<=BIAS. x_ready is 1 in the following cycle.
- Latency: y_valid rises the cycle after the last x handshake.
- Throughput: N_INPUTS+1 cycles per vector, given continuous valid and ready.
- y_sum and y_fire are don't-care while y_valid=0. The bench must check them only when y_valid=1.
- N_INPUTS=1: every handshake is the last one; the block goes straight to OUT.

Test Plan:
- ROM 1..6 = 1,3,4,5,6,8 and 7..10 = 0; BASE_ADDR=1, N=10, BIAS=0, THRESHOLD=20; ten x=1 back-to-back with x_last on the 10th -> y_sum=27, y_fire=1, y_valid 1 cycle after the 10th handshake, err=0.
- Same ROM, x=1..10 -> y_sum=117, y_fire=1. Check rom_addr sequence 2,3,…,10,1 on successive handshake cycles.
- x=-1 (0xFFFF) ×10 -> y_sum=-27 (40-bit two's complement), y_fire=0.
- x=1..10 with x_valid low for 3 cycles between every input -> y_sum=117. rom_addr and rom_dout hold across stalls.
- y_ready held low 5 cycles in OUT -> y_sum/y_fire stable, x_ready=0. Releasing it -> next all-ones vector yields 27.
- x_last asserted on input index 5 -> err=1 after that edge, vector still completes at 10 inputs. Separately: rst_n low after 4 inputs, then an all-ones vector -> y_sum=27, err=0.
